id_control_path: RTL and testbench
==================================

// Module: id_control_path
// PURPOSE
//  Decode-stage control path of the 5-stage ARM pipeline. Computes PC+4 for fetch, decodes the
//  IF/ID instruction into datapath control signals, and muxes them with a bubble (all-zero) source.
//  The selected controls are registered into ID/EX control outputs.
// PARAMETERS
//  PC_INC   4   constant added to pc_current for pc_plus_4
// PORTS
//  clk                 in   1   system clock, rising edge
//  reset               in   1   asynchronous, active-low reset (0 = reset)
//  pc_current          in   32  current program counter
//  instruction         in   32  IF/ID instruction
//  bubble_select       in   1   1 = force all controls to 0 (hazard/NOP insertion)
//  status_force_en     in   1   1 = status bits come from status_force instead of the decoder
//  status_force        in   2   externally forced status bits
//  pc_plus_4           out  32  pc_current + PC_INC, combinational
//  reg_write_enable    out  1   decoded controls after the mux, combinational (7 signals):
//  mem_write_enable    out  1
//  mem_to_reg_select   out  1
//  alu_source_select   out  1   1 = immediate operand
//  status_bits         out  2   [0] = S (update flags), [1] = compare-only (no writeback)
//  alu_operation       out  2   00 ADD, 01 SUB, 10 AND, 11 OR/pass
//  pc_source_select    out  1   1 = branch target
//  ex_<each of the above 7>  out  same widths  ID/EX registered copies
// BEHAVIOUR
//  - pc_plus_4: 32-bit modular add; 0xFFFFFFFC -> 0x00000000 with no carry out.
//  - Decoding is combinational on instruction[27:26]. Signals not listed for a class are 0.
//  - 00 data-processing: alu_source_select = bit25; status_bits[0] = bit20.
//    opcode = bits24:21. TST/TEQ/CMP/CMN (10xx): reg_write 0, status_bits[1] 1; otherwise reg_write 1.
//    alu_operation: ADD/ADC/CMN = 00; SUB/SBC/RSB/RSC/CMP = 01; AND/BIC/TST = 10;
//    ORR/EOR/TEQ/MOV/MVN = 11.
//  - 01 load/store: alu_source_select = ~bit25; alu_operation = bit23 (U) ? 00 : 01.
//    L = bit20. L = 1: reg_write 1, mem_to_reg 1. L = 0: mem_write 1.
//  - 10 branch: pc_source_select 1; reg_write = bit24 (BL writes LR); alu_operation 00.
//  - 11 (coprocessor/SWI), cond = 4'b1111, or instruction == 32'h0 (NOP): all controls 0.
//  - The condition field is otherwise not evaluated here; branch resolution is done downstream.
//  - Mux: bubble_select = 1 -> all 7 outputs 0, including status, overriding status_force_en.
//    Otherwise outputs equal the decode, except status_bits = status_force when status_force_en = 1.
//  - Register: ex_* load the muxed outputs on every rising clk (no stall). Latency 1 cycle.
//  - Reset low: all ex_* outputs go to 0 immediately and stay 0 while reset is low.
//    Combinational outputs are unaffected by reset.
//  - Reset asserted mid-operation: ex_* cleared asynchronously. The first edge after release
//    captures the current muxed values.
//  - No X propagation: every instruction value yields defined controls.
// STRUCTURE
//  - Package id_ctrl_pkg: instruction field bit positions, class codes (DP/LS/BR/CP),
//    DP opcode constants, ALU op encodings, and a control bundle struct (7 fields).
//  - Sub-module arm_ctrl_decoder: purely combinational instruction -> control bundle.
//  - Adder, mux, and ID/EX register stay inline in the top module.
// TESTING
//  - 0xE2110000 (ANDS R0,R1,#0) -> rw1 mw0 m2r0 src1 st01 op10 pcs0.
//    0xE0805183 (ADD R5,R0,R3,LSL#3) -> rw1 src0 st00 op00.
//  - 0xE7D12000 (LDRB) -> rw1 m2r1 mw0 src0 op00.
//    0xE58A5000 (STR) -> mw1 rw0 src1 op00.
//  - 0x1AFFFFFD (BNE) -> pcs1 rw0. 0xDB000009 (BLLE) -> pcs1 rw1.
//    0x00000000 -> all 0. 0xE3500000 (CMP) -> rw0 st11 op01.
//  - status_force_en = 1, status_force = 01 with ADD -> status_bits 01.
//    Then set bubble_select = 1 -> all outputs 0.
//  - Hold reset low 3 edges -> ex_* = 0. Release, apply ANDS -> ex_* match the decode after 1 edge.
//    Drop reset between edges -> ex_* = 0 without a clock edge.
//  - pc_current 0 -> pc_plus_4 4; 0xFFFFFFFC -> 0; sweep 0..48 in steps of 4 and check each +4.

Source files
------------

// File: rtl/id_ctrl_pkg.sv
// Shared definitions for the ID-stage control path: instruction field positions,
// class/opcode codes, ALU op encodings and the 7-signal control bundle.
package id_ctrl_pkg;

  localparam int COND_HI  = 31;
  localparam int COND_LO  = 28;
  localparam int CLASS_HI = 27;
  localparam int CLASS_LO = 26;
  localparam int BIT_I    = 25;
  localparam int BIT_LINK = 24;
  localparam int OPC_HI   = 24;
  localparam int OPC_LO   = 21;
  localparam int BIT_U    = 23;
  localparam int BIT_S    = 20;
  localparam int BIT_L    = 20;

  localparam logic [3:0] COND_NV = 4'b1111;

  typedef enum logic [1:0] {
    CLS_DP = 2'b00,
    CLS_LS = 2'b01,
    CLS_BR = 2'b10,
    CLS_CP = 2'b11
  } iclass_t;

  localparam logic [3:0] OPC_AND = 4'h0;
  localparam logic [3:0] OPC_EOR = 4'h1;
  localparam logic [3:0] OPC_SUB = 4'h2;
  localparam logic [3:0] OPC_RSB = 4'h3;
  localparam logic [3:0] OPC_ADD = 4'h4;
  localparam logic [3:0] OPC_ADC = 4'h5;
  localparam logic [3:0] OPC_SBC = 4'h6;
  localparam logic [3:0] OPC_RSC = 4'h7;
  localparam logic [3:0] OPC_TST = 4'h8;
  localparam logic [3:0] OPC_TEQ = 4'h9;
  localparam logic [3:0] OPC_CMP = 4'hA;
  localparam logic [3:0] OPC_CMN = 4'hB;
  localparam logic [3:0] OPC_ORR = 4'hC;
  localparam logic [3:0] OPC_MOV = 4'hD;
  localparam logic [3:0] OPC_BIC = 4'hE;
  localparam logic [3:0] OPC_MVN = 4'hF;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_op_t;

  // status[0] = S (update flags), status[1] = compare-only (no writeback)
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic [1:0] status;
    alu_op_t    alu_op;
    logic       pc_src;
  } ctrl_t;

  function automatic alu_op_t dp_alu_op(input logic [3:0] opcode);
    alu_op_t op;
    case (opcode)
      OPC_ADD, OPC_ADC, OPC_CMN:                   op = ALU_ADD;
      OPC_SUB, OPC_SBC, OPC_RSB, OPC_RSC, OPC_CMP: op = ALU_SUB;
      OPC_AND, OPC_BIC, OPC_TST:                   op = ALU_AND;
      default:                                     op = ALU_ORR;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/arm_ctrl_decoder.sv
// Purely combinational IF/ID instruction -> control bundle decode.
module arm_ctrl_decoder
  import id_ctrl_pkg::*;
(
  input  logic [31:0] instruction,
  output ctrl_t       ctrl
);

  iclass_t    iclass;
  logic [3:0] opcode;
  logic       is_nop;

  assign iclass = iclass_t'(instruction[CLASS_HI:CLASS_LO]);
  assign opcode = instruction[OPC_HI:OPC_LO];
  // Never-condition and the all-zero NOP both decode to a bubble
  assign is_nop = (instruction == 32'h0) ||
                  (instruction[COND_HI:COND_LO] == COND_NV);

  always_comb begin
    ctrl = '0;
    if (!is_nop) begin
      case (iclass)
        CLS_DP: begin
          ctrl.alu_src   = instruction[BIT_I];
          ctrl.status[0] = instruction[BIT_S];
          ctrl.alu_op    = dp_alu_op(opcode);
          if (opcode[3:2] == 2'b10) begin
            ctrl.status[1] = 1'b1;
          end else begin
            ctrl.reg_write = 1'b1;
          end
        end
        CLS_LS: begin
          // Register-offset form has I set, so the immediate is used when I is clear
          ctrl.alu_src = ~instruction[BIT_I];
          ctrl.alu_op  = instruction[BIT_U] ? ALU_ADD : ALU_SUB;
          if (instruction[BIT_L]) begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
          end else begin
            ctrl.mem_write  = 1'b1;
          end
        end
        CLS_BR: begin
          ctrl.pc_src    = 1'b1;
          ctrl.reg_write = instruction[BIT_LINK];
          ctrl.alu_op    = ALU_ADD;
        end
        default: ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/id_control_path.sv
// Decode-stage control path: PC+4, instruction decode, bubble/status-force mux and
// the ID/EX control register.
module id_control_path
  import id_ctrl_pkg::*;
#(
  parameter logic [31:0] PC_INC = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_current,
  input  logic [31:0] instruction,
  input  logic        bubble_select,
  input  logic        status_force_en,
  input  logic [1:0]  status_force,
  output logic [31:0] pc_plus_4,
  output logic        reg_write_enable,
  output logic        mem_write_enable,
  output logic        mem_to_reg_select,
  output logic        alu_source_select,
  output logic [1:0]  status_bits,
  output logic [1:0]  alu_operation,
  output logic        pc_source_select,
  output logic        ex_reg_write_enable,
  output logic        ex_mem_write_enable,
  output logic        ex_mem_to_reg_select,
  output logic        ex_alu_source_select,
  output logic [1:0]  ex_status_bits,
  output logic [1:0]  ex_alu_operation,
  output logic        ex_pc_source_select
);

  ctrl_t dec_ctrl;
  ctrl_t mux_ctrl;
  ctrl_t ex_ctrl;

  assign pc_plus_4 = pc_current + PC_INC;

  arm_ctrl_decoder u_decoder (
    .instruction (instruction),
    .ctrl        (dec_ctrl)
  );

  // Bubble wins over the status override
  always_comb begin
    mux_ctrl = dec_ctrl;
    if (status_force_en) mux_ctrl.status = status_force;
    if (bubble_select)   mux_ctrl = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ex_ctrl <= '0;
    else        ex_ctrl <= mux_ctrl;
  end

  assign reg_write_enable  = mux_ctrl.reg_write;
  assign mem_write_enable  = mux_ctrl.mem_write;
  assign mem_to_reg_select = mux_ctrl.mem_to_reg;
  assign alu_source_select = mux_ctrl.alu_src;
  assign status_bits       = mux_ctrl.status;
  assign alu_operation     = mux_ctrl.alu_op;
  assign pc_source_select  = mux_ctrl.pc_src;

  assign ex_reg_write_enable  = ex_ctrl.reg_write;
  assign ex_mem_write_enable  = ex_ctrl.mem_write;
  assign ex_mem_to_reg_select = ex_ctrl.mem_to_reg;
  assign ex_alu_source_select = ex_ctrl.alu_src;
  assign ex_status_bits       = ex_ctrl.status;
  assign ex_alu_operation     = ex_ctrl.alu_op;
  assign ex_pc_source_select  = ex_ctrl.pc_src;

endmodule

// File: tb/tb_id_control_path.sv
// Bench for id_control_path: directed vector table, reset sequences, PC sweep and
// random instructions against a behavioural decode model.
module tb_id_control_path;

  logic        clk;
  logic        reset;
  logic [31:0] pc_current;
  logic [31:0] instruction;
  logic        bubble_select;
  logic        status_force_en;
  logic [1:0]  status_force;
  logic [31:0] pc_plus_4;
  logic        reg_write_enable, mem_write_enable, mem_to_reg_select, alu_source_select;
  logic [1:0]  status_bits, alu_operation;
  logic        pc_source_select;
  logic        ex_reg_write_enable, ex_mem_write_enable, ex_mem_to_reg_select, ex_alu_source_select;
  logic [1:0]  ex_status_bits, ex_alu_operation;
  logic        ex_pc_source_select;

  int n_cmp = 0;
  int n_bad = 0;

  // {rw, mw, m2r, src, st[1:0], op[1:0], pcs}
  logic [8:0] exp_q[$];
  logic [8:0] dut_c, dut_ex;

  assign dut_c  = {reg_write_enable, mem_write_enable, mem_to_reg_select, alu_source_select,
                   status_bits, alu_operation, pc_source_select};
  assign dut_ex = {ex_reg_write_enable, ex_mem_write_enable, ex_mem_to_reg_select,
                   ex_alu_source_select, ex_status_bits, ex_alu_operation, ex_pc_source_select};

  id_control_path dut (
    .clk                  (clk),
    .reset                (reset),
    .pc_current           (pc_current),
    .instruction          (instruction),
    .bubble_select        (bubble_select),
    .status_force_en      (status_force_en),
    .status_force         (status_force),
    .pc_plus_4            (pc_plus_4),
    .reg_write_enable     (reg_write_enable),
    .mem_write_enable     (mem_write_enable),
    .mem_to_reg_select    (mem_to_reg_select),
    .alu_source_select    (alu_source_select),
    .status_bits          (status_bits),
    .alu_operation        (alu_operation),
    .pc_source_select     (pc_source_select),
    .ex_reg_write_enable  (ex_reg_write_enable),
    .ex_mem_write_enable  (ex_mem_write_enable),
    .ex_mem_to_reg_select (ex_mem_to_reg_select),
    .ex_alu_source_select (ex_alu_source_select),
    .ex_status_bits       (ex_status_bits),
    .ex_alu_operation     (ex_alu_operation),
    .ex_pc_source_select  (ex_pc_source_select)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic        bub;
    logic        fen;
    logic [1:0]  fst;
    logic [8:0]  exp;
  } vec_t;

  vec_t vecs[12];

  // Reference decode written from the instruction-class rules
  function automatic logic [8:0] model(input logic [31:0] ins, input logic bub,
                                       input logic fen, input logic [1:0] fst);
    logic rw, mw, m2r, src, pcs;
    logic [1:0] st, op;
    int cls, opc;
    rw = 0; mw = 0; m2r = 0; src = 0; pcs = 0; st = 0; op = 0;
    cls = int'(ins[27:26]);
    opc = int'(ins[24:21]);
    if (ins != 32'h0 && ins[31:28] != 4'hF) begin
      if (cls == 0) begin
        src = ins[25];
        st[0] = ins[20];
        if (opc >= 8 && opc <= 11) st[1] = 1; else rw = 1;
        if (opc == 4 || opc == 5 || opc == 11) op = 2'd0;
        else if (opc == 2 || opc == 3 || opc == 6 || opc == 7 || opc == 10) op = 2'd1;
        else if (opc == 0 || opc == 8 || opc == 14) op = 2'd2;
        else op = 2'd3;
      end else if (cls == 1) begin
        src = !ins[25];
        op = ins[23] ? 2'd0 : 2'd1;
        if (ins[20]) begin rw = 1; m2r = 1; end else mw = 1;
      end else if (cls == 2) begin
        pcs = 1;
        rw = ins[24];
      end
    end
    if (fen) st = fst;
    if (bub) return 9'd0;
    return {rw, mw, m2r, src, st, op, pcs};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // driver: apply at negedge, check combinational, then check ID/EX after the edge
  task automatic drive_and_check(input string nm, input logic [31:0] ins, input logic bub,
                                 input logic fen, input logic [1:0] fst, input logic [8:0] exp);
    logic [8:0] e;
    @(negedge clk);
    instruction = ins; bubble_select = bub; status_force_en = fen; status_force = fst;
    #1;
    check({nm, "_comb"}, {23'd0, dut_c}, {23'd0, exp});
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({nm, "_ex"}, {23'd0, dut_ex}, {23'd0, e});
  endtask

  initial begin
    reset = 1'b0;
    pc_current = 32'd0;
    instruction = 32'hE2110000;
    bubble_select = 0; status_force_en = 0; status_force = 2'b00;

    // reset held for 3 edges: ex stays 0, comb still decodes
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("reset_ex", {23'd0, dut_ex}, 32'd0);
    end
    check("reset_comb", {23'd0, dut_c}, {23'd0, 9'b1_0_0_1_01_10_0});
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("post_reset_ex", {23'd0, dut_ex}, {23'd0, 9'b1_0_0_1_01_10_0});
    #2 reset = 1'b0;
    #1 check("async_reset_ex", {23'd0, dut_ex}, 32'd0);
    @(posedge clk); #1;
    check("reset_hold_ex", {23'd0, dut_ex}, 32'd0);
    @(negedge clk); reset = 1'b1;

    vecs[0]  = '{32'hE2110000, 0, 0, 2'b00, 9'b1_0_0_1_01_10_0};
    vecs[1]  = '{32'hE0805183, 0, 0, 2'b00, 9'b1_0_0_0_00_00_0};
    vecs[2]  = '{32'hE7D12000, 0, 0, 2'b00, 9'b1_0_1_0_00_00_0};
    vecs[3]  = '{32'hE58A5000, 0, 0, 2'b00, 9'b0_1_0_1_00_00_0};
    vecs[4]  = '{32'h1AFFFFFD, 0, 0, 2'b00, 9'b0_0_0_0_00_00_1};
    vecs[5]  = '{32'hDB000009, 0, 0, 2'b00, 9'b1_0_0_0_00_00_1};
    vecs[6]  = '{32'h00000000, 0, 0, 2'b00, 9'b0_0_0_0_00_00_0};
    vecs[7]  = '{32'hE3500000, 0, 0, 2'b00, 9'b0_0_0_1_11_01_0};
    vecs[8]  = '{32'hE0805183, 0, 1, 2'b01, 9'b1_0_0_0_01_00_0};
    vecs[9]  = '{32'hE0805183, 1, 1, 2'b01, 9'b0_0_0_0_00_00_0};
    vecs[10] = '{32'hF2110000, 0, 0, 2'b00, 9'b0_0_0_0_00_00_0};
    vecs[11] = '{32'hEE000000, 0, 0, 2'b00, 9'b0_0_0_0_00_00_0};
    for (int i = 0; i < 12; i++) begin
      drive_and_check($sformatf("vec%0d", i), vecs[i].ins, vecs[i].bub, vecs[i].fen,
                      vecs[i].fst, vecs[i].exp);
    end

    // pc_plus_4 boundaries and sweep
    pc_current = 32'hFFFFFFFC; #1;
    check("pc_wrap", pc_plus_4, 32'h0);
    for (int p = 0; p <= 48; p += 4) begin
      pc_current = p; #1;
      check($sformatf("pc_sweep_%0d", p), pc_plus_4, p + 4);
    end

    // random instructions, with class bits spread evenly
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ins;
      logic bub, fen;
      logic [1:0] fst;
      ins = $urandom;
      if ($urandom_range(0, 9) == 0) ins[31:28] = 4'hF;
      ins[27:26] = 2'($urandom_range(0, 3));
      bub = ($urandom_range(0, 7) == 0);
      fen = ($urandom_range(0, 3) == 0);
      fst = 2'($urandom_range(0, 3));
      pc_current = $urandom;
      drive_and_check("rand", ins, bub, fen, fst, model(ins, bub, fen, fst));
      check("rand_pc", pc_plus_4, pc_current + 32'd4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
